multicycle_controller: RTL

//  Control unit for the multicycle MIPS datapath: a Moore FSM sequences fetch/decode/execute over 3-5 states per instr.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/aludec.sv | 28 ++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct encodings, FSM states and ALU op classes for the multicycle controller
package mips_ctrl_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ORIEX, S_IMMWB, S_JUMP
    } state_t;
    typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_OR} aluop_t;
endpackage

// File: rtl/aludec.sv
// aludec: maps ALU op class and R-type funct to the ALU control code
module aludec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [2:0] alucontrol,
    output logic       bad_funct
);
    logic [2:0] w_rtype;
    logic       w_known;
    always_comb begin
        w_rtype = ALU_ADD;
        w_known = 1'b1;
        case (funct)
            F_ADD:   w_rtype = ALU_ADD;
            F_SUB:   w_rtype = ALU_SUB;
            F_AND:   w_rtype = ALU_AND;
            F_OR:    w_rtype = ALU_OR;
            F_SLT:   w_rtype = ALU_SLT;
            default: w_known = 1'b0;
        endcase
        alucontrol = aluop == AOP_ADD ? ALU_ADD :
                     aluop == AOP_SUB ? ALU_SUB :
                     aluop == AOP_OR  ? ALU_OR  : w_rtype;
        bad_funct  = aluop == AOP_FUNCT && !w_known;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath, with memory
// wait-state handshake, illegal-op flag and a retired-instruction counter.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_BNE   = 1'b1,
    parameter bit EN_ORI   = 1'b1,
    parameter bit MEM_WAIT = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             imm_zext,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic [2:0]       alucontrol,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    state_t           r_state, w_next, w_dispatch;
    aluop_t           w_aluop;
    logic [CNT_W-1:0] r_count;
    logic             w_ready, w_bad_funct, w_retire;
    logic             w_memwrite, w_irwrite, w_pcen, w_regwrite;

    // only consulted in states that hold mem_req, so a stray ready is ignored
    assign w_ready = mem_ready || !MEM_WAIT;

    aludec u_aludec (
        .funct      (funct),
        .aluop      (w_aluop),
        .alucontrol (alucontrol),
        .bad_funct  (w_bad_funct)
    );

    always_comb begin
        w_dispatch = S_FETCH;
        case (op)
            OP_LW, OP_SW: w_dispatch = S_MEMADR;
            OP_R:         w_dispatch = S_EXEC;
            OP_BEQ:       w_dispatch = S_BRANCH;
            OP_BNE:       w_dispatch = EN_BNE ? S_BRANCH : S_FETCH;
            OP_ADDI:      w_dispatch = S_ADDIEX;
            OP_ORI:       w_dispatch = EN_ORI ? S_ORIEX : S_FETCH;
            OP_J:         w_dispatch = S_JUMP;
            default:      w_dispatch = S_FETCH;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        iord       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcen     = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        imm_zext   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_regwrite = 1'b0;
        w_aluop    = AOP_ADD;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = w_ready;
                w_pcen    = w_ready;
                w_next    = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = w_dispatch == S_FETCH;
                w_next     = w_dispatch;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = op == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                w_next  = w_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = w_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                w_aluop    = AOP_FUNCT;
                illegal_op = w_bad_funct;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                w_aluop = AOP_SUB;
                pcsrc   = 2'b01;
                w_pcen  = op == OP_BEQ ? zero : (EN_BNE && op == OP_BNE && !zero);
                w_next  = S_FETCH;
            end
            S_ADDIEX, S_ORIEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                w_aluop  = r_state == S_ORIEX ? AOP_OR : AOP_ADD;
                imm_zext = r_state == S_ORIEX;
                w_next   = S_IMMWB;
            end
            S_IMMWB: begin
                w_regwrite = 1'b1;
                imm_zext   = op == OP_ORI;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = 2'b10;
                w_pcen = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // write strobes are forced low the moment reset asserts, even mid-handshake
    assign memwrite = w_memwrite && reset_n;
    assign irwrite  = w_irwrite && reset_n;
    assign pcen     = w_pcen && reset_n;
    assign regwrite = w_regwrite && reset_n;

    assign w_retire    = w_next == S_FETCH && r_state != S_FETCH && r_state != S_DECODE;
    assign instr_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end
endmodule
